// File: rtl/onehot_decoder_reg.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes on both
// sides, a sticky mask of every decoded position and a count of accepted codes.
// Codes at or above OUT_W decode to all-zero with an error flag.
module onehot_decoder_reg #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             mask_clr,
    output logic [OUT_W-1:0] mask,
    output logic [CNT_W-1:0] acc_cnt
);

    // OUT_W never exceeds 2**IN_W, so it fits in IN_W+1 bits for the range test.
    localparam logic [IN_W:0] OUT_W_L = OUT_W[IN_W:0];

    // Decode a code into {err, onehot}; out-of-range codes give zero plus err.
    function automatic logic [OUT_W:0] decode_fn(input logic [IN_W-1:0] code);
        logic [OUT_W-1:0] onehot;
        logic             err;
        onehot = {OUT_W{1'b0}};
        err    = 1'b0;
        if ({1'b0, code} < OUT_W_L) begin
            onehot = {{(OUT_W-1){1'b0}}, 1'b1} << code;
            err    = 1'b0;
        end else begin
            onehot = {OUT_W{1'b0}};
            err    = 1'b1;
        end
        return {err, onehot};
    endfunction

    logic             in_ready_s;
    logic             accept_s;
    logic [OUT_W-1:0] dec_data_s;
    logic             dec_err_s;
    logic [OUT_W-1:0] mask_next_s;
    logic [OUT_W-1:0] out_data_r;
    logic             out_err_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] mask_r;
    logic [CNT_W-1:0] acc_cnt_r;

    // Handshake: accept when enabled and the output slot is free or draining now.
    always_comb begin
        in_ready_s = rst_n & en & (~out_valid_r | out_ready);
        accept_s   = in_valid & in_ready_s;
    end

    // Decode the incoming code and form the next sticky mask (clear before OR).
    always_comb begin
        {dec_err_s, dec_data_s} = decode_fn(in_code);
        mask_next_s = mask_r;
        if (accept_s) begin
            if (mask_clr) begin
                mask_next_s = dec_data_s;
            end else begin
                mask_next_s = mask_r | dec_data_s;
            end
        end else begin
            if (mask_clr) begin
                mask_next_s = {OUT_W{1'b0}};
            end else begin
                mask_next_s = mask_r;
            end
        end
    end

    // Output register: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= {OUT_W{1'b0}};
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_data_r  <= dec_data_s;
            out_err_r   <= dec_err_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_data_r  <= out_data_r;
            out_err_r   <= out_err_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_err_r   <= out_err_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky mask register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_r <= {OUT_W{1'b0}};
        end else begin
            mask_r <= mask_next_s;
        end
    end

    // Accepted-code counter, free-running wrap, unaffected by mask_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_cnt_r <= acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;
    assign out_valid = out_valid_r;
    assign mask      = mask_r;
    assign acc_cnt   = acc_cnt_r;

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Directed self-checking bench for onehot_decoder_reg. A second instance with
// OUT_W=6 exercises out-of-range codes; it has its own valid/ready inputs.
module tb_onehot_decoder_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       mask_clr;
    logic [7:0] mask;
    logic [7:0] acc_cnt;

    logic       in_valid6;
    logic       in_ready6;
    logic [5:0] out_data6;
    logic       out_err6;
    logic       out_valid6;
    logic       out_ready6;
    logic [5:0] mask6;
    logic [7:0] acc_cnt6;

    int nvec = 0;
    int nerr = 0;

    onehot_decoder_reg #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .mask_clr(mask_clr), .mask(mask), .acc_cnt(acc_cnt)
    );

    onehot_decoder_reg #(.IN_W(3), .OUT_W(6), .CNT_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code),
        .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
        .out_err(out_err6), .out_valid(out_valid6), .out_ready(out_ready6),
        .mask_clr(mask_clr), .mask(mask6), .acc_cnt(acc_cnt6)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_code = 3'd0; in_valid = 1'b0;
        out_ready = 1'b1; mask_clr = 1'b0; in_valid6 = 1'b0; out_ready6 = 1'b1;
        tick(); tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0h expected 0", out_valid); end
        nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %0h expected 0", out_data); end
        nvec++; if (out_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %0h expected 0", out_err); end
        nvec++; if (mask !== 8'h00) begin nerr++; $display("FAIL reset_mask: got %0h expected 0", mask); end
        nvec++; if (acc_cnt !== 8'h00) begin nerr++; $display("FAIL reset_cnt: got %0h expected 0", acc_cnt); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %0h expected 0", in_ready); end
        rst_n = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready: got %0h expected 1", in_ready); end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_data;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = i[2:0];
            tick();
            exp_data = 8'h01 << i;
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL sweep_valid[%0d]: got %0h expected 1", i, out_valid); end
            nvec++; if (out_data !== exp_data) begin nerr++; $display("FAIL sweep_data[%0d]: got %0h expected %0h", i, out_data, exp_data); end
            nvec++; if (out_err !== 1'b0) begin nerr++; $display("FAIL sweep_err[%0d]: got %0h expected 0", i, out_err); end
        end
        in_valid = 1'b0;
        nvec++; if (mask !== 8'hFF) begin nerr++; $display("FAIL sweep_mask: got %0h expected ff", mask); end
        nvec++; if (acc_cnt !== 8'd8) begin nerr++; $display("FAIL sweep_cnt: got %0h expected 8", acc_cnt); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drain_valid: got %0h expected 0", out_valid); end
        nvec++; if (out_data !== 8'h80) begin nerr++; $display("FAIL drain_data_kept: got %0h expected 80", out_data); end
    endtask

    task automatic test_backpressure();
        in_code = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        nvec++; if (out_data !== 8'h20) begin nerr++; $display("FAIL bp_first: got %0h expected 20", out_data); end
        in_code = 3'd2; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready[%0d]: got %0h expected 0", i, in_ready); end
            tick();
            nvec++; if (out_data !== 8'h20) begin nerr++; $display("FAIL bp_hold_data[%0d]: got %0h expected 20", i, out_data); end
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid[%0d]: got %0h expected 1", i, out_valid); end
            nvec++; if (acc_cnt !== 8'd9) begin nerr++; $display("FAIL bp_hold_cnt[%0d]: got %0h expected 9", i, acc_cnt); end
        end
        out_ready = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready: got %0h expected 1", in_ready); end
        tick();
        nvec++; if (out_data !== 8'h04) begin nerr++; $display("FAIL bp_second: got %0h expected 04", out_data); end
        nvec++; if (acc_cnt !== 8'd10) begin nerr++; $display("FAIL bp_cnt: got %0h expected 0a", acc_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        in_valid6 = 1'b1; in_code = 3'd4;
        tick();
        nvec++; if (out_data6 !== 6'h10) begin nerr++; $display("FAIL oor_prep_data: got %0h expected 10", out_data6); end
        in_code = 3'd7;
        tick();
        in_valid6 = 1'b0;
        nvec++; if (out_data6 !== 6'h00) begin nerr++; $display("FAIL oor_data: got %0h expected 0", out_data6); end
        nvec++; if (out_err6 !== 1'b1) begin nerr++; $display("FAIL oor_err: got %0h expected 1", out_err6); end
        nvec++; if (out_valid6 !== 1'b1) begin nerr++; $display("FAIL oor_valid: got %0h expected 1", out_valid6); end
        nvec++; if (acc_cnt6 !== 8'd2) begin nerr++; $display("FAIL oor_cnt: got %0h expected 2", acc_cnt6); end
        nvec++; if (mask6 !== 6'h10) begin nerr++; $display("FAIL oor_mask: got %0h expected 10", mask6); end
        nvec++; if (acc_cnt !== 8'd10) begin nerr++; $display("FAIL oor_main_idle_cnt: got %0h expected 0a", acc_cnt); end
        tick();
    endtask

    task automatic test_mask_clr();
        mask_clr = 1'b1; in_valid = 1'b0;
        tick();
        nvec++; if (mask !== 8'h00) begin nerr++; $display("FAIL clr_only: got %0h expected 0", mask); end
        mask_clr = 1'b0; in_valid = 1'b1; in_code = 3'd0;
        tick();
        in_code = 3'd7;
        tick();
        nvec++; if (mask !== 8'h81) begin nerr++; $display("FAIL clr_setup_mask: got %0h expected 81", mask); end
        mask_clr = 1'b1; in_code = 3'd3;
        tick();
        mask_clr = 1'b0; in_valid = 1'b0;
        nvec++; if (mask !== 8'h08) begin nerr++; $display("FAIL clr_with_accept: got %0h expected 08", mask); end
        nvec++; if (out_data !== 8'h08) begin nerr++; $display("FAIL clr_accept_data: got %0h expected 08", out_data); end
        nvec++; if (acc_cnt !== 8'd13) begin nerr++; $display("FAIL clr_cnt: got %0h expected 0d", acc_cnt); end
        tick();
    endtask

    task automatic test_en_low();
        out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd4;
        tick();
        nvec++; if (out_data !== 8'h10) begin nerr++; $display("FAIL en_pending: got %0h expected 10", out_data); end
        en = 1'b0; in_code = 3'd1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL en_in_ready: got %0h expected 0", in_ready); end
        tick();
        nvec++; if (out_data !== 8'h10) begin nerr++; $display("FAIL en_hold: got %0h expected 10", out_data); end
        out_ready = 1'b1; mask_clr = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL en_in_ready_drain: got %0h expected 0", in_ready); end
        tick();
        mask_clr = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL en_drain_valid: got %0h expected 0", out_valid); end
        nvec++; if (out_data !== 8'h10) begin nerr++; $display("FAIL en_drain_data: got %0h expected 10", out_data); end
        nvec++; if (acc_cnt !== 8'd14) begin nerr++; $display("FAIL en_cnt_frozen: got %0h expected 0e", acc_cnt); end
        nvec++; if (mask !== 8'h00) begin nerr++; $display("FAIL en_mask_clr: got %0h expected 0", mask); end
        en = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_reset_and_wrap();
        logic [2:0] c;
        // Counter is at 14: 241 more accepts reach 0xFF; codes 2..5 build 0x3C.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 241; k++) begin
            c = 3'd2 + 3'(k % 4);
            in_code = c;
            mask_clr = (k == 0) ? 1'b1 : 1'b0;
            tick();
        end
        mask_clr = 1'b0; in_valid = 1'b0;
        nvec++; if (acc_cnt !== 8'hFF) begin nerr++; $display("FAIL pre_rst_cnt: got %0h expected ff", acc_cnt); end
        nvec++; if (mask !== 8'h3C) begin nerr++; $display("FAIL pre_rst_mask: got %0h expected 3c", mask); end
        nvec++; if (out_data !== 8'h04) begin nerr++; $display("FAIL pre_rst_data: got %0h expected 04", out_data); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL pre_rst_valid: got %0h expected 1", out_valid); end
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %0h expected 0", out_valid); end
        nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL midrst_data: got %0h expected 0", out_data); end
        nvec++; if (mask !== 8'h00) begin nerr++; $display("FAIL midrst_mask: got %0h expected 0", mask); end
        nvec++; if (acc_cnt !== 8'h00) begin nerr++; $display("FAIL midrst_cnt: got %0h expected 0", acc_cnt); end
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_code = 3'd6;
        for (int k = 0; k < 255; k++) begin
            tick();
        end
        nvec++; if (acc_cnt !== 8'hFF) begin nerr++; $display("FAIL wrap_pre: got %0h expected ff", acc_cnt); end
        in_code = 3'd1;
        tick();
        in_valid = 1'b0;
        nvec++; if (acc_cnt !== 8'h00) begin nerr++; $display("FAIL wrap_cnt: got %0h expected 0", acc_cnt); end
        nvec++; if (out_data !== 8'h02) begin nerr++; $display("FAIL wrap_data: got %0h expected 02", out_data); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL wrap_valid: got %0h expected 1", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_out_of_range();
        test_mask_clr();
        test_en_low();
        test_reset_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
